alu_issue_decode: RTL and testbench

- Issue/decode stage that drives the ALU's `funct`, `data1` and `data2` inputs; it produces the control the ALU consumes.
- Accepts a 32-bit instruction plus two register-file read values over a valid/ready handshake.
- Decodes the opcode to the 4-bit ALU function code and selects the operands (register or immediate), then presents a registered bundle downstream.
- Includes a 2-entry skid buffer, so `in_ready` is a pure register output, plus a saturating issue counter.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_skid_buf.sv | 60 ++++++
 rtl/alu_issue_decode.sv | 90 +++++++++
 tb/tb_alu_issue_decode.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, opcodes, instruction field positions
// and the decoded bundle handed from issue/decode to the ALU.
package alu_pkg;
    localparam int ALU_DW = 32;

    localparam logic [3:0] CERO = 4'd0;
    localparam logic [3:0] ADD  = 4'd1;
    localparam logic [3:0] SUB  = 4'd2;
    localparam logic [3:0] AND  = 4'd3;
    localparam logic [3:0] OR   = 4'd4;
    localparam logic [3:0] NOT  = 4'd5;
    localparam logic [3:0] XOR  = 4'd6;
    localparam logic [3:0] LSL  = 4'd7;
    localparam logic [3:0] RSL  = 4'd8;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ALU_LO = 4'h1;
    localparam logic [3:0] OP_ALU_HI = 4'h8;
    localparam logic [3:0] OP_LDI    = 4'h9;
    localparam logic [3:0] OP_ILL_LO = 4'hA;

    localparam int OP_HI       = 31;
    localparam int OP_LO       = 28;
    localparam int IMM_SEL_BIT = 27;
    localparam int RD_HI       = 26;
    localparam int RD_LO       = 23;
    localparam int RS1_HI      = 22;
    localparam int RS1_LO      = 19;
    localparam int RS2_HI      = 18;
    localparam int RS2_LO      = 15;
    localparam int IMM_HI      = 14;
    localparam int IMM_LO      = 0;

    typedef struct packed {
        logic [3:0]        funct;
        logic [ALU_DW-1:0] data1;
        logic [ALU_DW-1:0] data2;
        logic [3:0]        rd;
        logic              illegal;
    } alu_bundle_t;
endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready register slice: an output register plus one skid
// entry, so in_ready comes straight from a flop.
module alu_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         r_out_vld;
    logic         r_skid_vld;
    logic         r_in_rdy;
    logic [W-1:0] r_out;
    logic [W-1:0] r_skid;
    logic         w_in_fire;
    logic         w_take;

    assign w_in_fire = in_valid & r_in_rdy & ~flush;
    // Output slot can be (re)loaded this cycle: empty or being consumed.
    assign w_take    = ~r_out_vld | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
            r_out      <= '0;
            r_skid     <= '0;
        end else if (flush) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_rdy   <= 1'b1;
        end else if (w_take) begin
            if (r_skid_vld) begin
                r_out      <= r_skid;
                r_out_vld  <= 1'b1;
                r_skid_vld <= w_in_fire;
                r_in_rdy   <= ~w_in_fire;
                if (w_in_fire) r_skid <= in_data;
            end else begin
                r_out_vld <= w_in_fire;
                if (w_in_fire) r_out <= in_data;
            end
        end else if (w_in_fire) begin
            r_skid     <= in_data;
            r_skid_vld <= 1'b1;
            r_in_rdy   <= 1'b0;
        end
    end

    assign in_ready  = r_in_rdy;
    assign out_valid = r_out_vld;
    assign out_data  = r_out;
endmodule

// File: rtl/alu_issue_decode.sv
// Issue/decode stage: decodes opcode to ALU funct, selects operands, and
// registers the bundle through a 2-entry skid slice; counts issued instructions.
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [DW-1:0]   rs1_data,
    input  logic [DW-1:0]   rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      funct,
    output logic [DW-1:0]   data1,
    output logic [DW-1:0]   data2,
    output logic [3:0]      rd,
    output logic            illegal,
    output logic [CNTW-1:0] issue_cnt
);
    typedef struct packed {
        logic [3:0]    funct;
        logic [DW-1:0] data1;
        logic [DW-1:0] data2;
        logic [3:0]    rd;
        logic          illegal;
    } bundle_t;

    localparam int BW = $bits(bundle_t);

    bundle_t         w_dec;
    bundle_t         w_out;
    logic [3:0]      w_op;
    logic [DW-1:0]   w_imm;
    logic            w_in_fire;
    logic            w_unused_rs;
    logic [CNTW-1:0] r_cnt;

    assign w_op        = instr[OP_HI:OP_LO];
    assign w_imm       = {{(DW-15){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
    // Register indices are resolved by the register file before this stage.
    assign w_unused_rs = ^instr[RS1_HI:RS2_LO];

    always_comb begin
        w_dec         = '0;
        w_dec.rd      = instr[RD_HI:RD_LO];
        if (w_op >= OP_ALU_LO && w_op <= OP_ALU_HI) begin
            w_dec.funct = w_op;
            w_dec.data1 = rs1_data;
            w_dec.data2 = instr[IMM_SEL_BIT] ? w_imm : rs2_data;
        end else if (w_op == OP_LDI) begin
            w_dec.funct = ADD;
            w_dec.data2 = w_imm;
        end else if (w_op >= OP_ILL_LO) begin
            w_dec.illegal = 1'b1;
        end
    end

    alu_skid_buf #(.W(BW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out)
    );

    assign funct   = w_out.funct;
    assign data1   = w_out.data1;
    assign data2   = w_out.data2;
    assign rd      = w_out.rd;
    assign illegal = w_out.illegal;

    assign w_in_fire = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       r_cnt <= '0;
        else if (w_in_fire && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end

    assign issue_cnt = r_cnt;
endmodule

// File: tb/tb_alu_issue_decode.sv
// Bench for alu_issue_decode: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_alu_issue_decode;
    localparam int DW   = 32;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     instr = '0;
    logic [DW-1:0]   rs1_data = '0;
    logic [DW-1:0]   rs2_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [3:0]      funct;
    logic [DW-1:0]   data1;
    logic [DW-1:0]   data2;
    logic [3:0]      rd;
    logic            illegal;
    logic [CNTW-1:0] issue_cnt;

    alu_issue_decode #(.DW(DW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .funct(funct), .data1(data1), .data2(data2), .rd(rd),
        .illegal(illegal), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  f;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   cnt_m = 0;
    int   checks = 0;
    int   errors = 0;
    bit   m_inf, m_outf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] b);
        exp_t e;
        int op;
        logic signed [14:0] s;
        logic [31:0] imm;
        op  = int'(ins[31:28]);
        s   = ins[14:0];
        imm = 32'(s);
        e.f = 4'd0; e.d1 = 32'd0; e.d2 = 32'd0; e.ill = 1'b0;
        e.rd = ins[26:23];
        if (op >= 1 && op <= 8) begin
            e.f  = 4'(op);
            e.d1 = a;
            e.d2 = ins[27] ? imm : b;
        end else if (op == 9) begin
            e.f  = 4'd1;
            e.d2 = imm;
        end else if (op >= 10) begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // Reference: in-order queue of at most two decoded bundles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cnt_m = 0;
        end else begin
            m_inf  = in_valid && (q.size() < 2) && !flush;
            m_outf = (q.size() > 0) && out_ready;
            if (m_outf) void'(q.pop_front());
            if (flush) q.delete();
            else if (m_inf) q.push_back(ref_decode(instr, rs1_data, rs2_data));
            if (m_inf && cnt_m < (1 << CNTW) - 1) cnt_m++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("funct", 64'(funct), 64'(q[0].f));
                chk("data1", 64'(data1), 64'(q[0].d1));
                chk("data2", 64'(data2), 64'(q[0].d2));
                chk("rd", 64'(rd), 64'(q[0].rd));
                chk("illegal", 64'(illegal), 64'(q[0].ill));
            end
            chk("issue_cnt", 64'(issue_cnt), 64'(cnt_m));
        end
    end

    function automatic logic [31:0] mk(input logic [3:0] op, input logic isel,
                                       input logic [3:0] rdi, input logic [3:0] r1,
                                       input logic [3:0] r2, input logic [14:0] imm);
        return {op, isel, rdi, r1, r2, imm};
    endfunction

    // Present one instruction and hold it until accepted (bounded).
    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bit acc;
        int guard;
        instr = ins; rs1_data = a; rs2_data = b; in_valid = 1'b1;
        guard = 0;
        do begin
            acc = in_ready && !flush;
            @(negedge clk);
            guard++;
        end while (!acc && guard < 50);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_funct", 64'(funct), 64'd0);
        chk("rst_data1", 64'(data1), 64'd0);
        chk("rst_data2", 64'(data2), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_cnt", 64'(issue_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(mk(4'h1, 1'b0, 4'd2, 4'd3, 4'd4, 15'h0), 32'd5, 32'd7);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_funct", 64'(funct), 64'd1);
        chk("add_data1", 64'(data1), 64'd5);
        chk("add_data2", 64'(data2), 64'd7);
        chk("add_rd", 64'(rd), 64'd2);
        chk("add_cnt", 64'(issue_cnt), 64'd1);

        send(mk(4'h2, 1'b1, 4'd5, 4'd1, 4'd0, 15'h7FFF), 32'd10, 32'd99);
        chk("sext_funct", 64'(funct), 64'd2);
        chk("sext_data1", 64'(data1), 64'd10);
        chk("sext_data2", 64'(data2), 64'hFFFF_FFFF);

        send(mk(4'h9, 1'b0, 4'd6, 4'd0, 4'd0, 15'h0123), 32'd77, 32'd88);
        chk("ldi_funct", 64'(funct), 64'd1);
        chk("ldi_data1", 64'(data1), 64'd0);
        chk("ldi_data2", 64'(data2), 64'h123);

        send(mk(4'hC, 1'b1, 4'd7, 4'd1, 4'd2, 15'h55), 32'd3, 32'd4);
        chk("ill_valid", 64'(out_valid), 64'd1);
        chk("ill_flag", 64'(illegal), 64'd1);
        chk("ill_funct", 64'(funct), 64'd0);
        chk("ill_data1", 64'(data1), 64'd0);
        chk("ill_data2", 64'(data2), 64'd0);
        chk("ill_cnt", 64'(issue_cnt), 64'd4);

        // Backpressure: A in output, B in skid, C refused until drain.
        @(negedge clk);
        out_ready = 1'b0;
        send(mk(4'h6, 1'b0, 4'd1, 4'd1, 4'd2, 15'h0), 32'hA0A0, 32'h0F0F);
        send(mk(4'h7, 1'b1, 4'd2, 4'd1, 4'd2, 15'h3), 32'hB0B0, 32'h0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_a", 64'(data1), 64'hA0A0);
        instr = mk(4'h4, 1'b0, 4'd3, 4'd1, 4'd2, 15'h0);
        rs1_data = 32'hC0C0; rs2_data = 32'h1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_c_refused", 64'(issue_cnt), 64'd6);
        chk("bp_still_a", 64'(data1), 64'hA0A0);
        chk("bp_a_funct", 64'(funct), 64'd6);
        out_ready = 1'b1;
        send(mk(4'h4, 1'b0, 4'd3, 4'd1, 4'd2, 15'h0), 32'hC0C0, 32'h1);
        chk("bp_out_c", 64'(data1), 64'hC0C0);
        chk("bp_cnt", 64'(issue_cnt), 64'd7);
        repeat (2) @(negedge clk);

        // Flush with both entries full and a new input offered.
        out_ready = 1'b0;
        send(mk(4'h3, 1'b0, 4'd4, 4'd1, 4'd2, 15'h0), 32'hD, 32'hE);
        send(mk(4'h5, 1'b1, 4'd5, 4'd1, 4'd2, 15'h7), 32'hE, 32'hF);
        instr = mk(4'h1, 1'b0, 4'd6, 4'd1, 4'd2, 15'h0);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_cnt", 64'(issue_cnt), 64'd9);

        // Saturation: 20 back-to-back accepts.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            send(mk(4'h1, 1'b1, 4'(i), 4'd0, 4'd0, 15'(i)), 32'(i), 32'd0);
        chk("sat_cnt", 64'(issue_cnt), 64'd15);

        // Asynchronous reset mid-cycle with entries in flight.
        out_ready = 1'b0;
        send(mk(4'h2, 1'b0, 4'd9, 4'd1, 4'd2, 15'h0), 32'h11, 32'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_cnt", 64'(issue_cnt), 64'd0);
        chk("arst_funct", 64'(funct), 64'd0);
        chk("arst_data1", 64'(data1), 64'd0);
        chk("arst_rd", 64'(rd), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send(mk(4'h8, 1'b0, 4'd3, 4'd1, 4'd2, 15'h0), 32'h80, 32'h3);
        chk("post_rst_funct", 64'(funct), 64'd8);
        chk("post_rst_cnt", 64'(issue_cnt), 64'd1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
